// File: rtl/serial_loader.sv
// Serial frame loader: shifts in a WIDTH-bit payload MSB first plus one even-parity bit,
// then presents the payload on data with a one-cycle enable strobe, or flags perr.
module serial_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic             sin,
  output logic [WIDTH-1:0] data,
  output logic             enable,
  output logic             busy,
  output logic             perr
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH:0]   shift_next;
  logic             frame_ok;

  // Extended vector keeps the shift legal for WIDTH == 1.
  assign shift_next = {shift_q, sin};
  // Even parity over payload plus the parity bit currently on sin.
  assign frame_ok   = ~(^{shift_q, sin});

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      data    <= '0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      perr    <= 1'b0;
    end else begin
      enable <= 1'b0;
      perr   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StShift;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StShift: begin
          shift_q <= shift_next[WIDTH-1:0];
          cnt_q   <= cnt_q + CntOne;
          if (cnt_q == LastBit) begin
            state_q <= StParity;
          end
        end
        StParity: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          if (frame_ok) begin
            data   <= shift_q;
            enable <= 1'b1;
          end else begin
            perr <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: frames, parity errors, ignored start, reset, back-to-back,
// plus a downstream enable register fed by data/enable.
module tb_serial_loader;

  logic       clk;
  logic       rst_;
  logic       start;
  logic       sin;
  logic [7:0] data;
  logic       enable;
  logic       busy;
  logic       perr;

  int checks;
  int errors;
  int cyc;
  int en_cnt;
  int perr_cnt;
  int both_cnt;
  int en_cyc[$];
  logic [7:0] reg_q;

  serial_loader #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .start  (start),
    .sin    (sin),
    .data   (data),
    .enable (enable),
    .busy   (busy),
    .perr   (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register that the loader is meant to drive.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) reg_q <= 8'h00;
    else if (enable) reg_q <= data;
  end

  // Pulse monitor, sampling 2 ns after each posedge.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (enable) begin
      en_cnt++;
      en_cyc.push_back(cyc);
    end
    if (perr) perr_cnt++;
    if (enable && perr) both_cnt++;
  end

  // Sends one frame; start_a/start_b pulse start during those payload bit slots.
  // Checks busy on every in-frame cycle; returns right after the parity edge.
  task automatic run_frame(input logic [7:0] p, input logic par, input int start_a,
                           input int start_b);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_start: got %b want 1", busy);
    end
    for (int i = 0; i < 8; i++) begin
      sin   = p[7-i];
      start = (i == start_a) || (i == start_b);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || enable !== 1'b0 || perr !== 1'b0) begin
        errors++;
        $display("FAIL busy_in_frame bit %0d: busy/en/perr=%b%b%b want 100", i, busy, enable,
                 perr);
      end
    end
    start = 1'b0;
    sin   = par;
    @(negedge clk);
    sin = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_parity: got %b want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_  = 1'b0;
    start = 1'b0;
    sin   = 1'b0;
    #1;
    checks++;
    if (data !== 8'h00 || enable !== 1'b0 || busy !== 1'b0 || perr !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h en=%b busy=%b perr=%b want 00 0 0 0", data, enable,
               busy, perr);
    end
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || enable !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b en=%b want 0 0", busy, enable);
    end
  endtask

  task automatic test_good_frame();
    int e0;
    e0 = en_cnt;
    run_frame(8'hA5, 1'b0, -1, -1);
    checks++;
    if (enable !== 1'b1 || perr !== 1'b0 || data !== 8'hA5) begin
      errors++;
      $display("FAIL good_a5: en=%b perr=%b data=%h want 1 0 a5", enable, perr, data);
    end
    @(negedge clk);
    checks++;
    if (enable !== 1'b0 || en_cnt - e0 != 1 || reg_q !== 8'hA5) begin
      errors++;
      $display("FAIL good_a5_pulse: en=%b pulses=%0d reg=%h want 0 1 a5", enable, en_cnt - e0,
               reg_q);
    end
  endtask

  task automatic test_bad_parity();
    int e0;
    int p0;
    e0 = en_cnt;
    p0 = perr_cnt;
    run_frame(8'h3C, 1'b1, -1, -1);
    checks++;
    if (perr !== 1'b1 || enable !== 1'b0 || data !== 8'hA5) begin
      errors++;
      $display("FAIL bad_3c: perr=%b en=%b data=%h want 1 0 a5", perr, enable, data);
    end
    @(negedge clk);
    checks++;
    if (perr !== 1'b0 || perr_cnt - p0 != 1 || en_cnt != e0 || reg_q !== 8'hA5) begin
      errors++;
      $display("FAIL bad_3c_pulse: perr=%b perrs=%0d ens=%0d reg=%h want 0 1 0 a5", perr,
               perr_cnt - p0, en_cnt - e0, reg_q);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      sin = i[0];
      @(negedge clk);
    end
    sin = 1'b0;
    checks++;
    if (data !== 8'hA5 || busy !== 1'b0 || reg_q !== 8'hA5) begin
      errors++;
      $display("FAIL hold_idle: data=%h busy=%b reg=%h want a5 0 a5", data, busy, reg_q);
    end
  endtask

  task automatic test_start_while_busy();
    int e0;
    e0 = en_cnt;
    run_frame(8'h0F, 1'b0, 2, 6);
    checks++;
    if (enable !== 1'b1 || data !== 8'h0F) begin
      errors++;
      $display("FAIL busy_start_0f: en=%b data=%h want 1 0f", enable, data);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (en_cnt - e0 != 1 || busy !== 1'b0 || reg_q !== 8'h0F) begin
      errors++;
      $display("FAIL busy_start_single: pulses=%0d busy=%b reg=%h want 1 0 0f", en_cnt - e0,
               busy, reg_q);
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    int p0;
    e0 = en_cnt;
    p0 = perr_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin = 1'b1;
      @(negedge clk);
    end
    #2;
    rst_ = 1'b0;
    #1;
    checks++;
    if (data !== 8'h00 || enable !== 1'b0 || busy !== 1'b0 || perr !== 1'b0 ||
        reg_q !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: data=%h en=%b busy=%b perr=%b reg=%h want 00 0 0 0 00", data,
               enable, busy, perr, reg_q);
    end
    @(negedge clk);
    rst_ = 1'b1;
    sin  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (en_cnt != e0 || perr_cnt != p0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: ens=%0d perrs=%0d busy=%b want 0 0 0", en_cnt - e0,
               perr_cnt - p0, busy);
    end
    run_frame(8'hFF, 1'b0, -1, -1);
    checks++;
    if (enable !== 1'b1 || data !== 8'hFF) begin
      errors++;
      $display("FAIL after_reset_ff: en=%b data=%h want 1 ff", enable, data);
    end
    @(negedge clk);
    checks++;
    if (en_cnt - e0 != 1 || reg_q !== 8'hFF) begin
      errors++;
      $display("FAIL after_reset_pulse: pulses=%0d reg=%h want 1 ff", en_cnt - e0, reg_q);
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    int n0;
    e0 = en_cnt;
    n0 = en_cyc.size();
    run_frame(8'h01, 1'b1, -1, -1);
    checks++;
    if (enable !== 1'b1 || data !== 8'h01) begin
      errors++;
      $display("FAIL b2b_first: en=%b data=%h want 1 01", enable, data);
    end
    run_frame(8'h80, 1'b1, -1, -1);
    checks++;
    if (enable !== 1'b1 || data !== 8'h80) begin
      errors++;
      $display("FAIL b2b_second: en=%b data=%h want 1 80", enable, data);
    end
    @(negedge clk);
    checks++;
    if (en_cnt - e0 != 2 || reg_q !== 8'h80) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d reg=%h want 2 80", en_cnt - e0, reg_q);
    end else begin
      checks++;
      if (en_cyc[n0+1] - en_cyc[n0] != 10) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d want 10", en_cyc[n0+1] - en_cyc[n0]);
      end
    end
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL en_perr_overlap: got %0d want 0", both_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    en_cnt   = 0;
    perr_cnt = 0;
    both_cnt = 0;
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_hold();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
